chan_pipe_buf: RTL and testbench
================================

// Module: chan_pipe_buf
// PURPOSE
//  Parametrised multi-channel registered buffer: CHANNELS lanes of WIDTH bits share one
//  valid/ready handshake and one DEPTH-entry elastic store. Generalises the single-bit
//  per-instance buffers with depth, flow control and an occupancy readout.
//  Sits between triplicated and non-triplicated domains as a TMRG test/infrastructure block.
// PARAMETERS
//  CHANNELS  6  number of lanes; bus width = CHANNELS*WIDTH
//  WIDTH     1  bits per lane
//  DEPTH     2  storage entries, >=1; CW = $clog2(DEPTH+1)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  in_data    in   CHANNELS*WIDTH  lane c at [c*WIDTH +: WIDTH]
//  in_valid   in   1               producer has a word
//  in_ready   out  1               buffer accepts a word this cycle
//  out_data   out  CHANNELS*WIDTH  head entry, lane order preserved
//  out_valid  out  1               head entry valid
//  out_ready  in   1               consumer takes head this cycle
//  count      out  CW              entries held
//  tmr_err    out  1               voter mismatch seen (sticky)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): count=0, out_valid=0, out_data=0, tmr_err=0, in_ready=1 next cycle.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; all state updates on clk edge.
//  - in_ready = (count != DEPTH); combinational from state only, never from out_ready.
//  - out_valid = (count != 0); out_data = oldest entry; all outputs registered/state-derived.
//  - Latency: word pushed at edge N is on out_data with out_valid=1 after edge N (1 cycle).
//  - Order: strict FIFO; all lanes of one word move together, no lane reordering.
//  - Storage: circular array, rd_ptr/wr_ptr modulo DEPTH; wrap from DEPTH-1 to 0.
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  - Full (count==DEPTH): in_ready=0; in_valid ignored even if pop occurs same cycle.
//  - Empty (count==0): pop impossible; out_data holds last popped value (0 after reset).
//  - push&pop at 0<count<DEPTH: both pointers advance, count constant.
//  - in_data sampled only on push; out_data/out_valid stable while out_valid & !out_ready.
//  - rst mid-transfer: all entries discarded, pointers=0, no output glitch beyond reset values.
//  - DEPTH=1: single register; alternates full/empty, throughput 1 word per 2 cycles max.
// CONFIGURATION
//  CHAN_PIPE_BUF_VOTER_EN defined:
//   - storage, pointers and count held in three copies; every read goes through bitwise
//     2-of-3 majority; each copy refreshed from the voted value every cycle (scrubbing).
//   - tmr_err set 1 the cycle after any copy disagrees with the vote; cleared only by rst.
//  CHAN_PIPE_BUF_VOTER_EN undefined:
//   - single copy of all state; tmr_err tied 0. Port list identical in both builds.
// TESTING
//  1 rst 3 cycles -> count=0, out_valid=0, in_ready=1, out_data=0, tmr_err=0.
//  2 CHANNELS=6,WIDTH=1: push 6'b101010 with out_ready=0 -> next cycle out_valid=1,
//    out_data=6'b101010, count=1; hold 5 cycles -> out_data unchanged.
//  3 DEPTH=2: push 0x2A,0x15,0x3F with out_ready=0 -> count=2, in_ready=0, 0x3F not stored;
//    then out_ready=1 -> outputs 0x2A then 0x15, count 1 then 0.
//  4 in_valid=out_ready=1 continuous, words 0..9 -> out_data 0..9 in order, one per cycle
//    after first, count steady 1, pointers wrap without loss.
//  5 rst asserted with count=2 -> next cycle count=0, out_valid=0; prior words never appear.
//  6 VOTER_EN: force one storage copy bit flip -> out_data still correct, tmr_err=1 next cycle,
//    stays 1 until rst; without VOTER_EN tmr_err=0 always.

Source files
------------

// File: rtl/chan_pipe_buf.sv
// CHANNELS x WIDTH lanes sharing one valid/ready handshake and a DEPTH-entry circular store; optional TMR via CHAN_PIPE_BUF_VOTER_EN.
// Latency 1 cycle push-to-out_valid; in_ready depends only on held count (never on out_ready), full blocks pushes even on a same-cycle pop.
module chan_pipe_buf #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 2,
  localparam int BW      = CHANNELS * WIDTH,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          tmr_err
);

`ifdef CHAN_PIPE_BUF_VOTER_EN
  localparam int NC = 3;
`else
  localparam int NC = 1;
`endif

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [BW-1:0] mem_q  [NC][DEPTH];
  logic [PW-1:0] rd_q   [NC];
  logic [PW-1:0] wr_q   [NC];
  logic [CW-1:0] cnt_q  [NC];
  logic [BW-1:0] last_q [NC];

  logic [BW-1:0] mem_v [DEPTH];
  logic [PW-1:0] rd_v, wr_v, rd_nxt, wr_nxt;
  logic [CW-1:0] cnt_v, cnt_nxt;
  logic [BW-1:0] last_v;
  logic          push, pop;

`ifdef CHAN_PIPE_BUF_VOTER_EN
  logic mis;

  // Bitwise 2-of-3 vote on every state element; mis flags any copy off the vote.
  always_comb begin
    mis = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      mem_v[d] = (mem_q[0][d] & mem_q[1][d]) | (mem_q[0][d] & mem_q[2][d]) | (mem_q[1][d] & mem_q[2][d]);
      mis = mis | (mem_q[0][d] != mem_v[d]) | (mem_q[1][d] != mem_v[d]) | (mem_q[2][d] != mem_v[d]);
    end
    rd_v   = (rd_q[0] & rd_q[1]) | (rd_q[0] & rd_q[2]) | (rd_q[1] & rd_q[2]);
    wr_v   = (wr_q[0] & wr_q[1]) | (wr_q[0] & wr_q[2]) | (wr_q[1] & wr_q[2]);
    cnt_v  = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
    last_v = (last_q[0] & last_q[1]) | (last_q[0] & last_q[2]) | (last_q[1] & last_q[2]);
    for (int i = 0; i < 3; i++) begin
      mis = mis | (rd_q[i] != rd_v) | (wr_q[i] != wr_v) | (cnt_q[i] != cnt_v) | (last_q[i] != last_v);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      tmr_err <= 1'b0;
    else if (mis) tmr_err <= 1'b1;
  end
`else
  always_comb begin
    for (int d = 0; d < DEPTH; d++) mem_v[d] = mem_q[0][d];
    rd_v   = rd_q[0];
    wr_v   = wr_q[0];
    cnt_v  = cnt_q[0];
    last_v = last_q[0];
  end

  assign tmr_err = 1'b0;
`endif

  assign in_ready  = (cnt_v != FULL);
  assign out_valid = (cnt_v != '0);
  // When empty, the last popped word is presented (zero after reset).
  assign out_data  = out_valid ? mem_v[rd_v] : last_v;
  assign count     = cnt_v;

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign rd_nxt = (rd_v == LAST_IDX) ? '0 : rd_v + 1'b1;
  assign wr_nxt = (wr_v == LAST_IDX) ? '0 : wr_v + 1'b1;

  always_comb begin
    cnt_nxt = cnt_v;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_v + 1'b1;
      2'b01:   cnt_nxt = cnt_v - 1'b1;
      default: cnt_nxt = cnt_v;
    endcase
  end

  // Every copy reloads from the voted value each cycle, so a single upset is scrubbed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        rd_q[i]   <= '0;
        wr_q[i]   <= '0;
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[i][d] <= '0;
      end else begin
        rd_q[i]   <= pop  ? rd_nxt : rd_v;
        wr_q[i]   <= push ? wr_nxt : wr_v;
        cnt_q[i]  <= cnt_nxt;
        last_q[i] <= pop ? mem_v[rd_v] : last_v;
        for (int d = 0; d < DEPTH; d++)
          mem_q[i][d] <= (push && (wr_v == PW'(d))) ? in_data : mem_v[d];
      end
    end
  end

endmodule

// File: tb/tb_chan_pipe_buf.sv
// Bench for chan_pipe_buf (CHANNELS=6, WIDTH=1, DEPTH=2): directed steps then random traffic against a queue model.
module tb_chan_pipe_buf;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;
  logic       tmr_err;

  int total = 0;
  int bad   = 0;

  logic [5:0] mq[$];
  logic [5:0] mlast;
  logic       exp_tmr;

  chan_pipe_buf #(.CHANNELS(6), .WIDTH(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .tmr_err(tmr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : mlast));
    chk("tmr_err", 32'(tmr_err), 32'(exp_tmr));
  endtask

  // Check the current state, then apply one cycle of inputs and advance the model.
  task automatic step(input logic iv, input logic [5:0] d, input logic ordy);
    bit do_push, do_pop;
    check_outputs();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    if (do_pop) mlast = mq.pop_front();
    if (do_push) mq.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mlast   = '0;
    exp_tmr = 1'b0;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    mlast = '0; exp_tmr = 1'b0;

    do_reset(3);

    step(1'b1, 6'b101010, 1'b0);
    repeat (5) step(1'b0, 6'h3F, 1'b0);
    chk("hold_data", 32'(out_data), 32'h2A);

    do_reset(1);
    step(1'b1, 6'h2A, 1'b0);
    step(1'b1, 6'h15, 1'b0);
    step(1'b1, 6'h3F, 1'b0);
    chk("full_count", 32'(count), 32'd2);
    step(1'b1, 6'h3F, 1'b1);
    chk("drain1", 32'(out_data), 32'h15);
    step(1'b0, 6'h00, 1'b1);
    step(1'b0, 6'h00, 1'b0);
    chk("empty_last", 32'(out_data), 32'h15);

    for (int w = 0; w < 10; w++) step(1'b1, 6'(w), 1'b1);
    step(1'b0, 6'h00, 1'b1);
    chk("stream_last", 32'(out_data), 32'd9);

    step(1'b1, 6'h11, 1'b0);
    step(1'b1, 6'h22, 1'b0);
    do_reset(1);
    chk("rst_data", 32'(out_data), 32'h0);
    step(1'b0, 6'h00, 1'b1);

`ifdef CHAN_PIPE_BUF_VOTER_EN
    step(1'b1, 6'h2A, 1'b0);
    dut.mem_q[1][0] = dut.mem_q[1][0] ^ 6'h01;
    step(1'b0, 6'h00, 1'b0);
    exp_tmr = 1'b1;
    repeat (3) step(1'b0, 6'h00, 1'b0);
    step(1'b0, 6'h00, 1'b1);
    do_reset(1);
`endif

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) do_reset(1);
      else step(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
